// File: rtl/fill_write_scheduler_if.sv
// Bundle of signals between the fill write scheduler, the Fill FIFO, the tag
// lookup read path and the DRAM-cache memory controller port.
// The scheduler takes the master modport because it drives the memory
// request; the surrounding blocks take the slave modport.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

interface fill_write_scheduler_if #(
   parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = `AXI_DATA_WIDTH
);
   logic                             fill_fifo_empty_i;
   logic                             fill_fifo_afull_i;
   logic                             fill_fifo_rden_o;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_fifo_rdata_i;
   logic                             rd_valid_i;
   logic [ADDR_WIDTH-1:0]            rd_addr_i;
   logic                             rd_ready_o;
   logic                             mem_valid_o;
   logic                             mem_ready_i;
   logic                             mem_we_o;
   logic [ADDR_WIDTH-1:0]            mem_addr_o;
   logic [DATA_WIDTH-1:0]            mem_wdata_o;

   modport master (
      input  fill_fifo_empty_i,
      input  fill_fifo_afull_i,
      output fill_fifo_rden_o,
      input  fill_fifo_rdata_i,
      input  rd_valid_i,
      input  rd_addr_i,
      output rd_ready_o,
      output mem_valid_o,
      input  mem_ready_i,
      output mem_we_o,
      output mem_addr_o,
      output mem_wdata_o
   );

   modport slave (
      output fill_fifo_empty_i,
      output fill_fifo_afull_i,
      input  fill_fifo_rden_o,
      output fill_fifo_rdata_i,
      output rd_valid_i,
      output rd_addr_i,
      input  rd_ready_o,
      input  mem_valid_o,
      output mem_ready_i,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_wdata_o
   );
endinterface

// File: rtl/fill_write_scheduler.sv
// Fill write scheduler: shares the single DRAM-cache memory port between demand
// reads and Fill FIFO drain writes. Reads win by default; a fill is forced when
// the FIFO is almost full or after STARVE_LIMIT reads were granted while fills
// were waiting. One request is in flight at a time, with an idle cycle between
// requests.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module fill_write_scheduler #(
   parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fill_write_scheduler_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WR,
      S_RD
   } state_t;

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      starve_cnt;
   logic [CNT_W-1:0]      starve_cnt_nxt;
   logic                  mem_valid_q;
   logic                  mem_valid_nxt;
   logic                  mem_we_q;
   logic                  mem_we_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] mem_wdata_nxt;
   logic                  fill_req;
   logic                  force_fill;
   logic                  grant_fill;
   logic                  grant_rd;
   logic                  rd_ready;
   logic                  fifo_rden;

   // Arbitration terms; only acted upon while the FSM sits in S_IDLE.
   assign fill_req   = !bus.fill_fifo_empty_i;
   assign force_fill = fill_req & (bus.fill_fifo_afull_i | (starve_cnt == STARVE_MAX));
   assign grant_fill = fill_req & (force_fill | !bus.rd_valid_i);
   assign grant_rd   = bus.rd_valid_i & !grant_fill;

   assign bus.rd_ready_o       = rd_ready;
   assign bus.fill_fifo_rden_o = fifo_rden;
   assign bus.mem_valid_o      = mem_valid_q;
   assign bus.mem_we_o         = mem_we_q;
   assign bus.mem_addr_o       = mem_addr_q;
   assign bus.mem_wdata_o      = mem_wdata_q;

   // State, starvation counter and the registered memory request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         starve_cnt  <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state       <= state_nxt;
         starve_cnt  <= starve_cnt_nxt;
         mem_valid_q <= mem_valid_nxt;
         mem_we_q    <= mem_we_nxt;
         mem_addr_q  <= mem_addr_nxt;
         mem_wdata_q <= mem_wdata_nxt;
      end
   end

   // Next-state decode: grant in IDLE, capture the popped entry, hold the request until accepted.
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      mem_valid_nxt  = mem_valid_q;
      mem_we_nxt     = mem_we_q;
      mem_addr_nxt   = mem_addr_q;
      mem_wdata_nxt  = mem_wdata_q;
      rd_ready       = 1'b0;
      fifo_rden      = 1'b0;
      case (state)
         S_IDLE: begin
            if (grant_fill) begin
               fifo_rden      = 1'b1;
               starve_cnt_nxt = '0;
               state_nxt      = S_POP;
            end else if (grant_rd) begin
               rd_ready      = 1'b1;
               mem_valid_nxt = 1'b1;
               mem_we_nxt    = 1'b0;
               mem_addr_nxt  = bus.rd_addr_i;
               mem_wdata_nxt = '0;
               state_nxt     = S_RD;
               if (fill_req && (starve_cnt != STARVE_MAX)) begin
                  starve_cnt_nxt = starve_cnt + 1'b1;
               end
            end
         end
         S_POP: begin
            mem_valid_nxt = 1'b1;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = bus.fill_fifo_rdata_i[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            mem_wdata_nxt = bus.fill_fifo_rdata_i[DATA_WIDTH-1:0];
            state_nxt     = S_WR;
         end
         S_WR, S_RD: begin
            if (bus.mem_ready_i) begin
               mem_valid_nxt = 1'b0;
               mem_we_nxt    = 1'b0;
               state_nxt     = S_IDLE;
            end
         end
      endcase
   end

endmodule
